// File: rtl/io_1ton_chk.sv
// One source sends addressed, per-sink sequence-numbered messages to NUM_SNK checking sinks over 4-phase handshakes.
// Define IO_1TON_ERR_CNT_EN to add a saturating per-sink error count; sink 0's count then appears on dbg_disp1.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module io_1ton_chk #(
  parameter int NUM_SNK  = 2,
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 4,
  parameter int SPAN_LOG = 1,
  parameter int SRC_ID   = 9,
  parameter int ASZ      = `NS_ADDRESS_SIZE,
  parameter int DSZ      = `NS_DATA_SIZE,
  parameter int RSZ      = `NS_REDUN_SIZE
) (
  input  logic                   src0_clk,
  input  logic                   reset,
  output logic [ASZ-1:0]         o0_src,
  output logic [ASZ-1:0]         o0_dst,
  output logic [DSZ-1:0]         o0_dat,
  output logic [RSZ-1:0]         o0_red,
  output logic                   o0_req,
  input  logic                   o0_ack,
  input  logic [NUM_SNK*ASZ-1:0] i_src,
  input  logic [NUM_SNK*ASZ-1:0] i_dst,
  input  logic [NUM_SNK*DSZ-1:0] i_dat,
  input  logic [NUM_SNK*RSZ-1:0] i_red,
  input  logic [NUM_SNK-1:0]     i_req,
  output logic [NUM_SNK-1:0]     i_ack,
  output logic [3:0]             dbg_leds,
  output logic [3:0]             dbg_disp0,
  output logic [3:0]             dbg_disp1
);

  localparam int KW = (NUM_SNK > 1) ? $clog2(NUM_SNK) : 1;
  localparam int FW = 2 * ASZ + DSZ;

  // Redundancy: XOR-fold of {src, dst, dat} into RSZ-bit chunks.
  function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] s,
                                                input logic [ASZ-1:0] d,
                                                input logic [DSZ-1:0] v);
    logic [FW-1:0]  flat;
    logic [RSZ-1:0] r;
    flat = {s, d, v};
    r    = '0;
    for (int i = 0; i < FW; i += RSZ) r = r ^ RSZ'(flat >> i);
    return r;
  endfunction

  typedef enum logic [2:0] {S_DST, S_DAT, S_RED, S_REQ, S_WAIT_ACK, S_WAIT_NACK} src_state_t;
  typedef enum logic [2:0] {K_IDLE, K_LATCH, K_REDUN, K_CHECK, K_ACK, K_WAIT_NREQ} snk_state_t;

  src_state_t     src_state_reg, src_state_next;
  logic [1:0]     ack_sync_reg;
  logic           ack_s;
  logic [ASZ-1:0] dst_reg;
  logic [DSZ-1:0] dat_reg;
  logic [RSZ-1:0] red_reg;
  logic           req_reg;
  logic [DSZ-1:0] cnt_reg [NUM_SNK];
  logic [ASZ-1:0] src_off;
  logic [KW-1:0]  src_k;

  assign ack_s   = ack_sync_reg[1];
  assign src_off = dst_reg - ASZ'(MIN_ADDR);
  assign src_k   = KW'(src_off >> SPAN_LOG);

  always_ff @(posedge src0_clk or posedge reset) begin
    if (reset) ack_sync_reg <= '0;
    else       ack_sync_reg <= {ack_sync_reg[0], o0_ack};
  end

  always_ff @(posedge src0_clk or posedge reset) begin
    if (reset) src_state_reg <= S_DST;
    else       src_state_reg <= src_state_next;
  end

  always_comb begin
    src_state_next = src_state_reg;
    case (src_state_reg)
      S_DST:       src_state_next = S_DAT;
      S_DAT:       src_state_next = S_RED;
      S_RED:       src_state_next = S_REQ;
      S_REQ:       src_state_next = S_WAIT_ACK;
      S_WAIT_ACK:  if (ack_s) src_state_next = S_WAIT_NACK;
      S_WAIT_NACK: if (!ack_s) src_state_next = S_DST;
      default:     src_state_next = S_DST;
    endcase
  end

  // dst resets to MAX_ADDR so the first DST step wraps it to MIN_ADDR.
  always_ff @(posedge src0_clk or posedge reset) begin
    if (reset) begin
      dst_reg <= ASZ'(MAX_ADDR);
      dat_reg <= '0;
      red_reg <= '0;
      req_reg <= 1'b0;
      for (int i = 0; i < NUM_SNK; i++) cnt_reg[i] <= '0;
    end else begin
      case (src_state_reg)
        S_DST: dst_reg <= (dst_reg == ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR) : dst_reg + ASZ'(1);
        S_DAT: begin
          dat_reg        <= cnt_reg[src_k];
          cnt_reg[src_k] <= cnt_reg[src_k] + DSZ'(1);
        end
        S_RED:      red_reg <= calc_redun(ASZ'(SRC_ID), dst_reg, dat_reg);
        S_REQ:      req_reg <= 1'b1;
        S_WAIT_ACK: if (ack_s) req_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o0_src = ASZ'(SRC_ID);
  assign o0_dst = dst_reg;
  assign o0_dat = dat_reg;
  assign o0_red = red_reg;
  assign o0_req = req_reg;

  logic [NUM_SNK-1:0] snk_err;
  logic [NUM_SNK-1:0] snk_ack;
  logic [3:0]         snk_disp [NUM_SNK];
`ifdef IO_1TON_ERR_CNT_EN
  logic [7:0]         snk_errcnt [NUM_SNK];
`endif

  for (genvar gi = 0; gi < NUM_SNK; gi++) begin : g_snk
    snk_state_t     state_reg, state_next;
    logic [1:0]     req_sync_reg;
    logic           req_s;
    logic [ASZ-1:0] cap_src_reg, cap_dst_reg;
    logic [DSZ-1:0] cap_dat_reg, last_dat_reg;
    logic [RSZ-1:0] cap_red_reg, calc_red_reg;
    logic           seen_reg, err_reg, ack_reg;
    logic [3:0]     disp_reg;
    logic [ASZ-1:0] off;
    logic           bad;

    assign req_s = req_sync_reg[1];
    assign off   = cap_dst_reg - ASZ'(MIN_ADDR);
    // Wrong owner, out of range, foreign source, bad redundancy, or sequence gap.
    assign bad = ((off >> SPAN_LOG) != ASZ'(gi))
              || (cap_dst_reg < ASZ'(MIN_ADDR)) || (cap_dst_reg > ASZ'(MAX_ADDR))
              || (cap_src_reg != ASZ'(SRC_ID)) || (cap_red_reg != calc_red_reg)
              || (seen_reg && (cap_dat_reg != last_dat_reg + DSZ'(1)));

    always_ff @(posedge src0_clk or posedge reset) begin
      if (reset) begin
        req_sync_reg <= '0;
        state_reg    <= K_IDLE;
      end else begin
        req_sync_reg <= {req_sync_reg[0], i_req[gi]};
        state_reg    <= state_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        K_IDLE:      if (req_s) state_next = K_LATCH;
        K_LATCH:     state_next = K_REDUN;
        K_REDUN:     state_next = K_CHECK;
        K_CHECK:     state_next = K_ACK;
        K_ACK:       state_next = K_WAIT_NREQ;
        K_WAIT_NREQ: if (!req_s) state_next = K_IDLE;
        default:     state_next = K_IDLE;
      endcase
    end

    always_ff @(posedge src0_clk or posedge reset) begin
      if (reset) begin
        cap_src_reg  <= '0;
        cap_dst_reg  <= '0;
        cap_dat_reg  <= '0;
        cap_red_reg  <= '0;
        calc_red_reg <= '0;
        last_dat_reg <= '0;
        seen_reg     <= 1'b0;
        err_reg      <= 1'b0;
        ack_reg      <= 1'b0;
        disp_reg     <= '0;
      end else begin
        case (state_reg)
          K_LATCH: begin
            cap_src_reg <= i_src[gi*ASZ +: ASZ];
            cap_dst_reg <= i_dst[gi*ASZ +: ASZ];
            cap_dat_reg <= i_dat[gi*DSZ +: DSZ];
            cap_red_reg <= i_red[gi*RSZ +: RSZ];
          end
          K_REDUN: calc_red_reg <= calc_redun(cap_src_reg, cap_dst_reg, cap_dat_reg);
          K_CHECK: begin
            if (bad) err_reg <= 1'b1;
            last_dat_reg <= cap_dat_reg;
            seen_reg     <= 1'b1;
            disp_reg     <= 4'(cap_dat_reg);
          end
          K_ACK:       ack_reg <= 1'b1;
          K_WAIT_NREQ: if (!req_s) ack_reg <= 1'b0;
          default: ;
        endcase
      end
    end

`ifdef IO_1TON_ERR_CNT_EN
    logic [7:0] errcnt_reg;
    always_ff @(posedge src0_clk or posedge reset) begin
      if (reset)                                                   errcnt_reg <= '0;
      else if (state_reg == K_CHECK && bad && errcnt_reg != 8'hFF) errcnt_reg <= errcnt_reg + 8'd1;
    end
    assign snk_errcnt[gi] = errcnt_reg;
`endif

    assign snk_err[gi]  = err_reg;
    assign snk_ack[gi]  = ack_reg;
    assign snk_disp[gi] = disp_reg;
  end

  assign i_ack     = snk_ack;
  assign dbg_leds  = {src_state_reg == S_WAIT_ACK, snk_err[NUM_SNK-1], snk_err[0], |snk_err};
  assign dbg_disp0 = snk_disp[0];
`ifdef IO_1TON_ERR_CNT_EN
  assign dbg_disp1 = snk_errcnt[0][3:0];
`else
  assign dbg_disp1 = snk_disp[NUM_SNK-1];
`endif

endmodule

// File: tb/tb_io_1ton_chk.sv
// Scoreboard bench for io_1ton_chk: loopback traffic, data wrap, corrupted/misrouted messages, mid-handshake reset.
module tb_io_1ton_chk;
  localparam int NUM_SNK  = 2;
  localparam int MIN_ADDR = 1;
  localparam int MAX_ADDR = 4;
  localparam int SPAN_LOG = 1;
  localparam int SRC_ID   = 9;

  logic        src0_clk = 1'b0;
  logic        reset    = 1'b1;
  logic [7:0]  o0_src, o0_dst, o0_dat, o0_red;
  logic        o0_req;
  logic        o0_ack   = 1'b0;
  logic [15:0] i_src = '0, i_dst = '0, i_dat = '0, i_red = '0;
  logic [1:0]  i_req = '0;
  logic [1:0]  i_ack;
  logic [3:0]  dbg_leds, dbg_disp0, dbg_disp1;

  io_1ton_chk #(
    .NUM_SNK(NUM_SNK), .MIN_ADDR(MIN_ADDR), .MAX_ADDR(MAX_ADDR), .SPAN_LOG(SPAN_LOG),
    .SRC_ID(SRC_ID), .ASZ(8), .DSZ(8), .RSZ(8)
  ) dut (
    .src0_clk(src0_clk), .reset(reset),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red),
    .o0_req(o0_req), .o0_ack(o0_ack),
    .i_src(i_src), .i_dst(i_dst), .i_dat(i_dat), .i_red(i_red),
    .i_req(i_req), .i_ack(i_ack),
    .dbg_leds(dbg_leds), .dbg_disp0(dbg_disp0), .dbg_disp1(dbg_disp1)
  );

  always #5 src0_clk = ~src0_clk;

  typedef struct packed {logic [7:0] dst; logic [7:0] dat; logic [7:0] red;} src_exp_t;
  typedef struct packed {logic err; logic any; logic [3:0] disp; logic [3:0] cnt;} snk_exp_t;

  src_exp_t src_q[$];
  snk_exp_t snk0_q[$];
  snk_exp_t snk1_q[$];
  int   checks = 0;
  int   errors = 0;
  logic m_err [2];
  int   m_errcnt = 0;

  // With 8-bit fields the redundancy fold reduces to src ^ dst ^ dat.
  function automatic logic [7:0] redun(input logic [7:0] s, input logic [7:0] d, input logic [7:0] v);
    return s ^ d ^ v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Message m after reset: dst cycles 1..4; each sink owns two addresses, so its data is 2*(m/4)+m%2.
  task automatic push_src(input int m);
    src_exp_t e;
    e.dst = 8'(1 + m % 4);
    e.dat = 8'(2 * (m / 4) + m % 2);
    e.red = redun(8'(SRC_ID), e.dst, e.dat);
    src_q.push_back(e);
  endtask

  task automatic wait_ack(input int k, input logic lvl, input string name);
    int n = 0;
    while (i_ack[k] !== lvl && n < 100) begin
      @(negedge src0_clk);
      n++;
    end
    if (i_ack[k] !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: i_ack[%0d] timed out at %b, required %b", name, k, i_ack[k], lvl);
    end
  endtask

  task automatic wait_req(input logic lvl, input string name);
    int n = 0;
    while (o0_req !== lvl && n < 200) begin
      @(negedge src0_clk);
      n++;
    end
    if (o0_req !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: o0_req timed out at %b, required %b", name, o0_req, lvl);
    end
  endtask

  task automatic send_sink(input int k, input logic [7:0] s, input logic [7:0] d, input logic [7:0] v,
                           input logic [7:0] r, input logic bad, input logic [3:0] edisp);
    snk_exp_t e;
    m_err[k] = m_err[k] | bad;
    if (k == 0 && bad && m_errcnt < 255) m_errcnt++;
    e.err  = m_err[k];
    e.any  = m_err[0] | m_err[1];
    e.disp = edisp;
    e.cnt  = 4'(m_errcnt);
    if (k == 0) snk0_q.push_back(e);
    else        snk1_q.push_back(e);
    @(negedge src0_clk);
    i_src[k*8 +: 8] = s;
    i_dst[k*8 +: 8] = d;
    i_dat[k*8 +: 8] = v;
    i_red[k*8 +: 8] = r;
    i_req[k]        = 1'b1;
    wait_ack(k, 1'b1, "ack_rise");
    i_req[k] = 1'b0;
    wait_ack(k, 1'b0, "ack_fall");
  endtask

  task automatic do_reset();
    @(negedge src0_clk);
    reset = 1'b1;
    #1;
    check("rst_o0_req", o0_req, 0);
    check("rst_i_ack", i_ack, 0);
    repeat (2) @(negedge src0_clk);
    check("rst_o0_dst", o0_dst, MAX_ADDR);
    check("rst_o0_dat", o0_dat, 0);
    check("rst_leds", dbg_leds, 0);
    check("rst_disp0", dbg_disp0, 0);
    check("rst_disp1", dbg_disp1, 0);
    m_err[0] = 1'b0;
    m_err[1] = 1'b0;
    m_errcnt = 0;
    push_src(0);
    reset = 1'b0;
  endtask

  initial begin : src_mon
    logic     prev = 1'b0;
    src_exp_t e;
    forever begin
      @(negedge src0_clk);
      if (o0_req && !prev) begin
        if (src_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL src_unexpected: message dst=%0d dat=%0d appeared, required none", o0_dst, o0_dat);
        end else begin
          e = src_q.pop_front();
          check("src_dst", o0_dst, e.dst);
          check("src_dat", o0_dat, e.dat);
          check("src_red", o0_red, e.red);
          check("src_id", o0_src, SRC_ID);
        end
      end
      prev = o0_req;
    end
  end

  initial begin : snk_mon
    logic [1:0] prev = 2'b00;
    snk_exp_t   e;
    forever begin
      @(negedge src0_clk);
      for (int k = 0; k < 2; k++) begin
        if (i_ack[k] && !prev[k]) begin
          if ((k == 0 && snk0_q.size() == 0) || (k == 1 && snk1_q.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL snk_unexpected: sink %0d acked with no message pending, required none", k);
          end else begin
            if (k == 0) e = snk0_q.pop_front();
            else        e = snk1_q.pop_front();
            if (k == 0) check("snk0_err", dbg_leds[1], e.err);
            else        check("snk1_err", dbg_leds[2], e.err);
            check("snk_any_err", dbg_leds[0], e.any);
`ifdef IO_1TON_ERR_CNT_EN
            if (k == 0) begin
              check("snk0_disp", dbg_disp0, e.disp);
              check("snk0_errcnt", dbg_disp1, e.cnt);
            end
`else
            if (k == 0) check("snk0_disp", dbg_disp0, e.disp);
            else        check("snk1_disp", dbg_disp1, e.disp);
`endif
          end
        end
      end
      prev = i_ack;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    do_reset();

    // Loopback: forward each source message to its owning sink, then ack the source.
    for (int m = 0; m < 40; m++) begin
      wait_req(1'b1, "lb_req_rise");
      send_sink((m % 4) / 2, o0_src, o0_dst, o0_dat, o0_red, 1'b0, 4'(2 * (m / 4) + m % 2));
      push_src(m + 1);
      o0_ack = 1'b1;
      wait_req(1'b0, "lb_req_fall");
      o0_ack = 1'b0;
    end
    wait_req(1'b1, "lb_last_req");
    repeat (2) @(negedge src0_clk);
    check("led_wait_ack", dbg_leds[3], 1);
    check("lb_no_errs", dbg_leds[2:0], 0);

    // Reset while o0_req is high: req must drop immediately, source restarts at dst=1, dat=0.
    check("req_before_rst", o0_req, 1);
    do_reset();

    // Sink 0 data wraps 255 -> 0 without error.
    for (int i = 0; i < 260; i++) begin
      logic [7:0] d, v;
      d = 8'(1 + i % 2);
      v = 8'(i);
      send_sink(0, 8'(SRC_ID), d, v, redun(8'(SRC_ID), d, v), 1'b0, v[3:0]);
    end

    // Sink 1 message 5 has a flipped redundancy bit; error sticks, later messages still acked.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d, v, r;
      d = 8'(3 + i % 2);
      v = 8'(i);
      r = redun(8'(SRC_ID), d, v) ^ ((i == 5) ? 8'h01 : 8'h00);
      send_sink(1, 8'(SRC_ID), d, v, r, i == 5, v[3:0]);
    end
    check("snk1_sticky", dbg_leds[2], 1);

    // dst=3 belongs to sink 1: only sink 0 flags it.
    do_reset();
    send_sink(0, 8'(SRC_ID), 8'd3, 8'd0, redun(8'(SRC_ID), 8'd3, 8'd0), 1'b1, 4'd0);
    check("snk1_clean", dbg_leds[2], 0);

    // Many misrouted messages on sink 0: error count saturates, handshake never stalls.
    for (int i = 1; i <= 300; i++) begin
      logic [7:0] v;
      v = 8'(i);
      send_sink(0, 8'(SRC_ID), 8'd3, v, redun(8'(SRC_ID), 8'd3, v), 1'b1, v[3:0]);
    end

    repeat (4) @(negedge src0_clk);
    check("src_q_drained", src_q.size(), 0);
    check("snk0_q_drained", snk0_q.size(), 0);
    check("snk1_q_drained", snk1_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
